// File: rtl/if_id_buffer.sv
// if_id_buffer: in-order queue between instruction fetch and decode.
// It stores {PC+4, Instruction} pairs from fetch and presents the oldest
// pair to decode. When the queue is full and decode stalls, it raises
// freeze so that fetch holds its PC. A taken branch discards every queued
// pair and also drops the wrong-path pair presented in that same cycle.
// Optional build macro IF_ID_PERF_EN adds saturating counters for freeze
// cycles and flushed entries, together with their output ports.
module if_id_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] Instruction,
  input  logic             Branch_taken,
  input  logic             id_stall,
  output logic             freeze,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] Instruction_out,
  output logic             valid_out
`ifdef IF_ID_PERF_EN
  ,
  output logic [15:0]      freeze_cycles,
  output logic [15:0]      flushed_entries
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [2*WIDTH-1:0] storage_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               full, empty, wr_en, rd_en;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Outputs come straight from the head entry so that decode sees a newly
  // written pair one cycle after fetch presents it.
  assign valid_out       = !empty;
  assign PC_out          = empty ? '0 : storage_q[rd_ptr_q][2*WIDTH-1:WIDTH];
  assign Instruction_out = empty ? '0 : storage_q[rd_ptr_q][WIDTH-1:0];
  assign freeze          = full & id_stall & !Branch_taken;

  // A write at full is accepted only because a read frees a slot in the
  // same cycle. Otherwise freeze is high and the write is blocked.
  assign wr_en = !freeze & !Branch_taken;
  assign rd_en = !empty & !id_stall & !Branch_taken;

  // Next state for the pointers and occupancy when there is no flush.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, rd_en};
  end

  // Update the pointers and occupancy. Reset has priority, then flush,
  // then normal operation.
  always_ff @(posedge clk) begin
    if (rst || Branch_taken) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Each storage slot captures the fetch pair when the write pointer
  // selects it. Every slot clears on reset so the outputs read zero.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          storage_q[gi] <= '0;
        end else if (wr_en && (wr_ptr_q == PTR_W'(gi))) begin
          storage_q[gi] <= {PC, Instruction};
        end
      end
    end
  endgenerate

`ifdef IF_ID_PERF_EN
  logic [15:0] freeze_cycles_q, freeze_cycles_d;
  logic [15:0] flushed_entries_q, flushed_entries_d;
  logic [16:0] flush_sum;

  assign flush_sum = {1'b0, flushed_entries_q} + 17'(count_q);

  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    freeze_cycles_d   = freeze_cycles_q;
    flushed_entries_d = flushed_entries_q;
    if (freeze && (freeze_cycles_q != 16'hFFFF)) begin
      freeze_cycles_d = freeze_cycles_q + 16'd1;
    end
    if (Branch_taken) begin
      flushed_entries_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end

  // Register the counters. Reset clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      freeze_cycles_q   <= '0;
      flushed_entries_q <= '0;
    end else begin
      freeze_cycles_q   <= freeze_cycles_d;
      flushed_entries_q <= flushed_entries_d;
    end
  end

  assign freeze_cycles   = freeze_cycles_q;
  assign flushed_entries = flushed_entries_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed and randomized checks of if_id_buffer against a
// queue-based reference model of the fetch/decode buffer.
module tb_if_id_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] Instruction;
  logic             Branch_taken;
  logic             id_stall;
  logic             freeze;
  logic [WIDTH-1:0] PC_out;
  logic [WIDTH-1:0] Instruction_out;
  logic             valid_out;
`ifdef IF_ID_PERF_EN
  logic [15:0]      freeze_cycles;
  logic [15:0]      flushed_entries;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {PC, Instruction} pairs and the perf counters.
  logic [2*WIDTH-1:0] mq[$];
  int unsigned        m_fc = 0;
  int unsigned        m_fe = 0;
  logic [WIDTH-1:0]   br_target = 32'h104;

  if_id_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .PC              (PC),
    .Instruction     (Instruction),
    .Branch_taken    (Branch_taken),
    .id_stall        (id_stall),
    .freeze          (freeze),
    .PC_out          (PC_out),
    .Instruction_out (Instruction_out),
    .valid_out       (valid_out)
`ifdef IF_ID_PERF_EN
    ,
    .freeze_cycles   (freeze_cycles),
    .flushed_entries (flushed_entries)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic e_valid();
    return mq.size() != 0;
  endfunction

  function automatic logic [WIDTH-1:0] e_pc();
    logic [2*WIDTH-1:0] h;
    if (mq.size() == 0) return '0;
    h = mq[0];
    return h[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] e_ins();
    logic [2*WIDTH-1:0] h;
    if (mq.size() == 0) return '0;
    h = mq[0];
    return h[WIDTH-1:0];
  endfunction

  function automatic logic e_freeze();
    return (mq.size() == DEPTH) && id_stall && !Branch_taken;
  endfunction

  // Advance one clock. The model is updated from the inputs sampled at the
  // edge. The fetch side then follows its own rules: it redirects on a
  // branch, holds while frozen, and otherwise moves on by 4 with a new word.
  // The next inputs are applied at the following falling edge.
  task automatic tick();
    logic             f;
    logic             br;
    logic [WIDTH-1:0] npc;
    logic [WIDTH-1:0] nins;
    f    = e_freeze();
    br   = Branch_taken;
    npc  = PC;
    nins = Instruction;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_fc = 0;
      m_fe = 0;
    end else if (br) begin
      m_fe = (m_fe + mq.size() > 32'hFFFF) ? 32'hFFFF : m_fe + mq.size();
      mq.delete();
    end else begin
      if (f && m_fc < 32'hFFFF) m_fc++;
      if (mq.size() != 0 && !id_stall) void'(mq.pop_front());
      if (!f) mq.push_back({PC, Instruction});
    end
    if (br) begin
      npc  = br_target;
      nins = $urandom;
    end else if (!f) begin
      npc  = PC + 32'd4;
      nins = $urandom;
    end
    @(negedge clk);
    PC          = npc;
    Instruction = nins;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; Branch_taken = 1'b0; id_stall = 1'b0;
    tick();
    rst = 1'b0;
    PC = 32'd4;
    Instruction = $urandom;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (PC_out !== '0) begin errors++; $display("FAIL reset_pc: got %h expected 0", PC_out); end
    checks++; if (Instruction_out !== '0) begin errors++; $display("FAIL reset_ins: got %h expected 0", Instruction_out); end
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %b expected 0", freeze); end
    $display("test_reset done: valid=%b pc=%h freeze=%b", valid_out, PC_out, freeze);
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] exp_pc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = 32'd4 * (i + 1);
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, valid_out); end
      checks++; if (PC_out !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, PC_out, exp_pc); end
      checks++; if (Instruction_out !== e_ins()) begin errors++; $display("FAIL stream_ins[%0d]: got %h expected %h", i, Instruction_out, e_ins()); end
      checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL stream_freeze[%0d]: got %b expected 0", i, freeze); end
      $display("stream cycle %0d: pc_out=%h valid=%b freeze=%b", i, PC_out, valid_out, freeze);
    end
  endtask

  task automatic test_stall_release();
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] exp_seq[4];
    exp_seq[0] = 32'd4; exp_seq[1] = 32'd8; exp_seq[2] = 32'd12; exp_seq[3] = 32'd16;
    do_reset();
    id_stall = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (PC_out !== 32'd4) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 4", i, PC_out); end
      checks++; if (freeze !== (i >= 1)) begin errors++; $display("FAIL stall_freeze[%0d]: got %b expected %b", i, freeze, (i >= 1)); end
      $display("stall cycle %0d: pc_out=%h freeze=%b", i, PC_out, freeze);
    end
    id_stall = 1'b0;
    #1;
    // Full and not stalled: the read and the write happen together.
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL full_rw_freeze: got %b expected 0", freeze); end
    for (int i = 0; i < 4; i++) begin
      if (valid_out) got.push_back(PC_out);
      tick();
      if (i == 0) begin
        checks++; if (dut.count_q !== 2'd2) begin errors++; $display("FAIL full_rw_count: got %0d expected 2", dut.count_q); end
      end
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL release_len: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_seq[i]) begin errors++; $display("FAIL release_order[%0d]: got %h expected %h", i, got[i], exp_seq[i]); end
      $display("release out %0d: pc=%h", i, got[i]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    id_stall = 1'b1;
    #1;
    tick(); tick();
    Branch_taken = 1'b1;
    br_target = 32'h104;
    #1;
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL flush_freeze_same: got %b expected 0", freeze); end
    tick();
    Branch_taken = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", valid_out); end
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL flush_freeze: got %b expected 0", freeze); end
    id_stall = 1'b0;
    #1;
    tick();
    checks++; if (PC_out !== 32'h104) begin errors++; $display("FAIL flush_head: got %h expected 104", PC_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL flush_head_valid: got %b expected 1", valid_out); end
    $display("flush: head pc=%h valid=%b", PC_out, valid_out);
  endtask

  task automatic test_reset_full();
    do_reset();
    id_stall = 1'b1;
    #1;
    tick(); tick(); tick();
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL prereset_freeze: got %b expected 1", freeze); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rstfull_valid: got %b expected 0", valid_out); end
    checks++; if (PC_out !== '0) begin errors++; $display("FAIL rstfull_pc: got %h expected 0", PC_out); end
    checks++; if (Instruction_out !== '0) begin errors++; $display("FAIL rstfull_ins: got %h expected 0", Instruction_out); end
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL rstfull_freeze: got %b expected 0", freeze); end
    $display("reset while full: valid=%b pc=%h freeze=%b", valid_out, PC_out, freeze);
    id_stall = 1'b0;
  endtask

`ifdef IF_ID_PERF_EN
  task automatic test_perf();
    do_reset();
    id_stall = 1'b1;
    #1;
    tick(); tick();
    tick(); tick(); tick();
    Branch_taken = 1'b1;
    #1;
    tick();
    Branch_taken = 1'b0;
    id_stall = 1'b0;
    #1;
    checks++; if (freeze_cycles !== 16'd3) begin errors++; $display("FAIL perf_freeze: got %0d expected 3", freeze_cycles); end
    checks++; if (flushed_entries !== 16'd2) begin errors++; $display("FAIL perf_flushed: got %0d expected 2", flushed_entries); end
    $display("perf: freeze_cycles=%0d flushed_entries=%0d", freeze_cycles, flushed_entries);
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      Branch_taken = ($urandom_range(0, 7) == 0);
      id_stall     = ($urandom_range(0, 1) == 1);
      br_target    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      #1;
      checks++;
      if (valid_out !== e_valid() || PC_out !== e_pc() || Instruction_out !== e_ins() || freeze !== e_freeze()) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b pc=%h ins=%h frz=%b expected v=%b pc=%h ins=%h frz=%b",
                 i, valid_out, PC_out, Instruction_out, freeze, e_valid(), e_pc(), e_ins(), e_freeze());
      end
`ifdef IF_ID_PERF_EN
      checks++;
      if (freeze_cycles !== 16'(m_fc) || flushed_entries !== 16'(m_fe)) begin
        errors++;
        $display("FAIL random_perf[%0d]: got fc=%0d fe=%0d expected fc=%0d fe=%0d", i, freeze_cycles, flushed_entries, m_fc, m_fe);
      end
`endif
      $display("random %0d: rst=%b br=%b stall=%b pc_in=%h -> v=%b pc_out=%h frz=%b", i, rst, Branch_taken, id_stall, PC, valid_out, PC_out, freeze);
      tick();
    end
    rst = 1'b0; Branch_taken = 1'b0; id_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Branch_taken = 1'b0; id_stall = 1'b0;
    PC = '0; Instruction = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall_release();
    test_flush();
    test_reset_full();
`ifdef IF_ID_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
